// File: rtl/dorodon_rom_loader_if.sv
// HPS download stream into the loader, and the loader's ROM write port and status back out.
interface dorodon_rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic        cpu_we;
  logic        gfx_we;
  logic        spr_we;
  logic        prom_we;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        core_reset;
  logic        rom_valid;
  logic        rom_error;
  logic [16:0] byte_count;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  cpu_we, gfx_we, spr_we, prom_we, wr_addr, wr_data,
    input  core_reset, rom_valid, rom_error, byte_count
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output cpu_we, gfx_we, spr_we, prom_we, wr_addr, wr_data,
    output core_reset, rom_valid, rom_error, byte_count
  );
endinterface

// File: rtl/dorodon_rom_loader.sv
// Splits the HPS ROM stream into CPU/tile/sprite/PROM writes, validates it,
// and holds the game core in reset until a complete image has settled.
module dorodon_rom_loader #(
  parameter int CPU_SIZE    = 32768,
  parameter int GFX_SIZE    = 8192,
  parameter int SPR_SIZE    = 8192,
  parameter int PROM_SIZE   = 256,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  dorodon_rom_loader_if.slave  bus
);
  localparam logic [24:0] GFX_BASE  = 25'(CPU_SIZE);
  localparam logic [24:0] SPR_BASE  = 25'(CPU_SIZE + GFX_SIZE);
  localparam logic [24:0] PROM_BASE = 25'(CPU_SIZE + GFX_SIZE + SPR_SIZE);
  localparam logic [24:0] TOTAL     = 25'(CPU_SIZE + GFX_SIZE + SPR_SIZE + PROM_SIZE);
  localparam logic [16:0] TOTAL_CNT = 17'(CPU_SIZE + GFX_SIZE + SPR_SIZE + PROM_SIZE);
  localparam logic [16:0] CNT_MAX   = '1;
  localparam int          HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_HOLD, S_RUN, S_ERROR} state_t;

  typedef struct packed {
    logic [3:0]  we;    // {prom, spr, gfx, cpu}
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_req_t;

  state_t         state_q, state_d;
  wr_req_t        req_d, req_q;
  logic [16:0]    cnt_q;
  logic           err_q;
  logic [HW-1:0]  hold_q;
  logic           core_reset_q, rom_valid_q, rom_error_q;
  logic           core_reset_d, rom_valid_d, rom_error_d;
  logic           take, in_seq, in_range, accept, load_entry;

  assign take       = (state_q == S_LOAD) && bus.ioctl_wr;
  assign in_seq     = (bus.ioctl_addr == {8'd0, cnt_q});
  assign in_range   = (bus.ioctl_addr < TOTAL);
  assign accept     = take && in_seq && in_range;
  assign load_entry = (state_q != S_LOAD) && (state_d == S_LOAD);

  // region decode on the raw stream address; gated off unless the byte is accepted
  always_comb begin
    req_d      = '0;
    req_d.data = bus.ioctl_dout;
    if (bus.ioctl_addr < GFX_BASE) begin
      req_d.we   = 4'b0001;
      req_d.addr = 16'(bus.ioctl_addr);
    end else if (bus.ioctl_addr < SPR_BASE) begin
      req_d.we   = 4'b0010;
      req_d.addr = 16'(bus.ioctl_addr - GFX_BASE);
    end else if (bus.ioctl_addr < PROM_BASE) begin
      req_d.we   = 4'b0100;
      req_d.addr = 16'(bus.ioctl_addr - SPR_BASE);
    end else begin
      req_d.we   = 4'b1000;
      req_d.addr = 16'(bus.ioctl_addr - PROM_BASE);
    end
    if (!accept) req_d.we = '0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      req_q <= '0;
    end else begin
      req_q.we <= req_d.we;
      if (accept) begin
        req_q.addr <= req_d.addr;
        req_q.data <= req_d.data;
      end
    end
  end

  // a byte landing on the same edge download drops is still counted before CHECK looks
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (load_entry) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (take) begin
      if (in_seq && in_range) begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 17'd1;
      end else begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset || state_q != S_HOLD) hold_q <= '0;
    else                            hold_q <= hold_q + 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      core_reset_q <= 1'b1;
      rom_valid_q  <= 1'b0;
      rom_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_reset_q <= core_reset_d;
      rom_valid_q  <= rom_valid_d;
      rom_error_q  <= rom_error_d;
    end
  end

  // status is registered from the next state so a reload from RUN drops
  // rom_valid and raises core_reset on the very next edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.ioctl_download)  state_d = S_LOAD;
      S_LOAD:  if (!bus.ioctl_download) state_d = S_CHECK;
      S_CHECK: state_d = (cnt_q == TOTAL_CNT && !err_q) ? S_HOLD : S_ERROR;
      S_HOLD:  if (hold_q == HOLD_LAST) state_d = S_RUN;
      S_RUN:   if (bus.ioctl_download)  state_d = S_LOAD;
      S_ERROR: if (bus.ioctl_download)  state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
    core_reset_d = (state_d != S_RUN);
    rom_valid_d  = (state_d == S_RUN);
    rom_error_d  = (state_d == S_ERROR);
  end

  assign bus.cpu_we     = req_q.we[0];
  assign bus.gfx_we     = req_q.we[1];
  assign bus.spr_we     = req_q.we[2];
  assign bus.prom_we    = req_q.we[3];
  assign bus.wr_addr    = req_q.addr;
  assign bus.wr_data    = req_q.data;
  assign bus.core_reset = core_reset_q;
  assign bus.rom_valid  = rom_valid_q;
  assign bus.rom_error  = rom_error_q;
  assign bus.byte_count = cnt_q;
endmodule

// File: tb/tb_dorodon_rom_loader.sv
// Randomized stream bench for dorodon_rom_loader against a byte-level model of the image layout.
module tb_dorodon_rom_loader;
  localparam int CPU   = 1024;
  localparam int GFX   = 256;
  localparam int SPR   = 256;
  localparam int PROM  = 64;
  localparam int HOLD  = 100;
  localparam int TOTAL = CPU + GFX + SPR + PROM;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  dorodon_rom_loader_if bus();

  dorodon_rom_loader #(
    .CPU_SIZE(CPU), .GFX_SIZE(GFX), .SPR_SIZE(SPR), .PROM_SIZE(PROM), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk  = 0;
  int n_pass = 0;
  int m_cnt;
  bit m_err;
  int nwe [4];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [3:0] we_vec();
    return {bus.prom_we, bus.spr_we, bus.gfx_we, bus.cpu_we};
  endfunction

  task automatic begin_load();
    bus.ioctl_download = 1'b1;
    tick();
    m_cnt = 0;
    m_err = 1'b0;
    nwe   = '{0, 0, 0, 0};
    chk("load_core_reset", bus.core_reset, 1);
    chk("load_rom_valid", bus.rom_valid, 0);
    chk("load_byte_count", bus.byte_count, 0);
    chk("load_rom_error", bus.rom_error, 0);
  endtask

  // model: the byte lands only if it is the next expected one and inside the image
  task automatic send(input int a, input bit drop);
    logic [3:0] exp_we;
    int         exp_off;
    logic [7:0] d;
    exp_we  = 4'b0000;
    exp_off = 0;
    d       = 8'($urandom_range(255));
    if (a == m_cnt && a < TOTAL) begin
      if (a < CPU)                  begin exp_we = 4'b0001; exp_off = a; end
      else if (a < CPU + GFX)       begin exp_we = 4'b0010; exp_off = a - CPU; end
      else if (a < CPU + GFX + SPR) begin exp_we = 4'b0100; exp_off = a - CPU - GFX; end
      else                          begin exp_we = 4'b1000; exp_off = a - CPU - GFX - SPR; end
      m_cnt++;
    end else begin
      m_err = 1'b1;
    end
    if ($urandom_range(3) == 0) begin
      tick();
      chk("idle_we", we_vec(), 0);
    end
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'(a);
    bus.ioctl_dout = d;
    if (drop) bus.ioctl_download = 1'b0;
    tick();
    bus.ioctl_wr = 1'b0;
    chk($sformatf("we@%0d", a), we_vec(), exp_we);
    if (exp_we != 0) begin
      chk($sformatf("wr_addr@%0d", a), bus.wr_addr, exp_off);
      chk($sformatf("wr_data@%0d", a), bus.wr_data, d);
    end
    chk($sformatf("byte_count@%0d", a), bus.byte_count, m_cnt);
    for (int r = 0; r < 4; r++) if (we_vec()[r]) nwe[r]++;
  endtask

  task automatic end_dl();
    bus.ioctl_download = 1'b0;
    tick();
  endtask

  // called right after the edge that moves LOAD into CHECK
  task automatic outcome();
    int n;
    n = 0;
    if (m_cnt == TOTAL && !m_err) begin
      while (bus.core_reset && n < HOLD + 20) begin
        tick();
        n++;
      end
      chk("hold_len", n, HOLD + 1);
      chk("run_rom_valid", bus.rom_valid, 1);
      chk("run_rom_error", bus.rom_error, 0);
      chk("run_byte_count", bus.byte_count, TOTAL);
    end else begin
      tick();
      chk("err_rom_error", bus.rom_error, 1);
      chk("err_rom_valid", bus.rom_valid, 0);
      chk("err_byte_count", bus.byte_count, m_cnt);
      repeat (5) tick();
      chk("err_core_reset", bus.core_reset, 1);
    end
  endtask

  task automatic full_image(input bit coincident_drop);
    for (int a = 0; a < TOTAL - 1; a++) send(a, 1'b0);
    send(TOTAL - 1, coincident_drop);
  endtask

  task automatic check_regions();
    chk("n_cpu_we", nwe[0], CPU);
    chk("n_gfx_we", nwe[1], GFX);
    chk("n_spr_we", nwe[2], SPR);
    chk("n_prom_we", nwe[3], PROM);
  endtask

  task automatic stray_wr();
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'(0);
    bus.ioctl_dout = 8'hA5;
    tick();
    bus.ioctl_wr = 1'b0;
    tick();
    chk("stray_we", we_vec(), 0);
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    reset              = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_we", we_vec(), 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_core_reset", bus.core_reset, 1);
    chk("rst_rom_valid", bus.rom_valid, 0);
    chk("rst_rom_error", bus.rom_error, 0);
    chk("rst_byte_count", bus.byte_count, 0);

    stray_wr();
    chk("idle_byte_count", bus.byte_count, 0);

    // full image, last byte coincident with download falling
    begin_load();
    full_image(1'b1);
    check_regions();
    outcome();

    stray_wr();
    chk("run_stray_count", bus.byte_count, TOTAL);
    chk("run_stray_core_reset", bus.core_reset, 0);

    // reload from RUN
    begin_load();
    full_image(1'b0);
    end_dl();
    check_regions();
    outcome();

    // short image
    begin_load();
    for (int a = 0; a < TOTAL - 1; a++) send(a, 1'b0);
    end_dl();
    outcome();

    // gap in the stream
    begin_load();
    for (int a = 0; a < 100; a++) send(a, 1'b0);
    send(101, 1'b0);
    end_dl();
    outcome();
    chk("gap_byte_count", bus.byte_count, 100);

    // one byte past the end
    begin_load();
    full_image(1'b0);
    send(TOTAL, 1'b0);
    end_dl();
    outcome();

    // reset in the middle of HOLD
    begin_load();
    full_image(1'b0);
    end_dl();
    repeat (HOLD / 2 + 1) tick();
    chk("mid_hold_core_reset", bus.core_reset, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("hold_rst_core_reset", bus.core_reset, 1);
    chk("hold_rst_rom_valid", bus.rom_valid, 0);
    chk("hold_rst_byte_count", bus.byte_count, 0);
    repeat (HOLD + 5) tick();
    chk("hold_rst_stays_idle", bus.core_reset, 1);
    begin_load();
    full_image(1'b0);
    end_dl();
    outcome();

    // reset mid-LOAD with download still high: remainder breaks contiguity
    begin_load();
    for (int a = 0; a < 300; a++) send(a, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("load_rst_we", we_vec(), 0);
    chk("load_rst_byte_count", bus.byte_count, 0);
    tick();
    m_cnt = 0;
    m_err = 1'b0;
    for (int a = 300; a < 400; a++) send(a, 1'b0);
    end_dl();
    outcome();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
